// File: rtl/noise.sv
// Deterministic channel-error mask generator: raises noise_sig for BURST
// consecutive cycles out of every INTERVAL cycles, restarting on reset.
module noise #(
  parameter int INTERVAL = 15,
  parameter int BURST    = 1
) (
  input  logic clk_sig,
  input  logic reset_sig,
  output logic noise_sig
);

  localparam int CW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [CW-1:0] LAST   = CW'(INTERVAL - 1);
  localparam logic [CW-1:0] THRESH = CW'(INTERVAL - BURST);

  if (INTERVAL < 1) begin : g_bad_interval
    $error("noise: INTERVAL must be >= 1");
  end
  if (BURST < 1) begin : g_bad_burst_low
    $error("noise: BURST must be >= 1");
  end
  if (BURST > INTERVAL) begin : g_bad_burst_high
    $error("noise: BURST must not exceed INTERVAL");
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic          noise_q, noise_d;
  logic          in_burst;

  // A burst covering the whole period needs no compare; it also avoids a
  // degenerate "cnt >= 0" comparison.
  if (BURST >= INTERVAL) begin : g_always_on
    assign in_burst = 1'b1;
  end else begin : g_compare
    assign in_burst = (cnt_q >= THRESH);
  end

  always_comb begin
    cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    noise_d = in_burst;
  end

  always_ff @(posedge clk_sig) begin
    if (!reset_sig) begin
      cnt_q   <= '0;
      noise_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      noise_q <= noise_d;
    end
  end

  assign noise_sig = noise_q;

endmodule

// File: tb/tb_noise.sv
// Scoreboard bench for noise: four parameterisations share clock and reset;
// stimulus queues expected masks, a monitor pops and compares after each edge.
module tb_noise;

  logic clk_sig;
  logic reset_sig;
  logic noise_a, noise_b, noise_c, noise_d;

  noise #(.INTERVAL(15), .BURST(1)) u_a (.clk_sig(clk_sig), .reset_sig(reset_sig), .noise_sig(noise_a));
  noise #(.INTERVAL(8),  .BURST(3)) u_b (.clk_sig(clk_sig), .reset_sig(reset_sig), .noise_sig(noise_b));
  noise #(.INTERVAL(1),  .BURST(1)) u_c (.clk_sig(clk_sig), .reset_sig(reset_sig), .noise_sig(noise_c));
  noise #(.INTERVAL(4),  .BURST(4)) u_d (.clk_sig(clk_sig), .reset_sig(reset_sig), .noise_sig(noise_d));

  typedef struct {
    int k;
    int phase;
    bit ea;
    bit eb;
    bit ec;
    bit ed;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   ones_a = 0;
  int   ones_b = 0;
  int   k = 0;
  int   phase = 0;

  initial clk_sig = 1'b0;
  always #5 clk_sig = ~clk_sig;

  // Hand form of the pattern: pulse lands on every multiple of I edges after
  // release, and the burst extends back over the B-1 edges before it.
  function automatic bit pattern(input int kk, input int i, input int b);
    if (kk == 0) return 1'b0;
    return ((kk % i) == 0) || ((kk % i) > (i - b));
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic drive(input bit rst_n);
    exp_t e;
    @(negedge clk_sig);
    reset_sig = rst_n;
    if (!rst_n) k = 0;
    else        k++;
    e.k     = k;
    e.phase = phase;
    e.ea    = pattern(k, 15, 1);
    e.eb    = pattern(k, 8, 3);
    e.ec    = pattern(k, 1, 1);
    e.ed    = pattern(k, 4, 4);
    sb_q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 5 && sb_q.size() != 0; i++) @(posedge clk_sig);
    #2;
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_sig);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check($sformatf("i15b1 k=%0d", e.k), noise_a, e.ea);
        check($sformatf("i8b3 k=%0d",  e.k), noise_b, e.eb);
        check($sformatf("i1 k=%0d",    e.k), noise_c, e.ec);
        check($sformatf("i4b4 k=%0d",  e.k), noise_d, e.ed);
        if (e.phase == 1 && e.k >= 1 && e.k <= 1000) ones_a += int'(noise_a);
        if (e.phase == 1 && e.k >= 1 && e.k <= 80)   ones_b += int'(noise_b);
      end
    end
  end

  // Absolute-time checks on the first two pulses after release at 20 ns.
  initial begin
    #160 check("t160", noise_a, 1'b0);
    #10  check("t170", noise_a, 1'b1);
    #10  check("t180", noise_a, 1'b0);
    #130 check("t310", noise_a, 1'b0);
    #10  check("t320", noise_a, 1'b1);
    #10  check("t330", noise_a, 1'b0);
  end

  // Stimulus
  initial begin
    reset_sig = 1'b0;
    phase = 1;
    drive(1'b0);
    for (int i = 0; i < 1000; i++) drive(1'b1);
    drain();
    tests++;
    if (ones_a != 66) begin
      fails++;
      $display("FAIL duty_i15: got %0d ones expected 66", ones_a);
    end
    tests++;
    if (ones_b != 30) begin
      fails++;
      $display("FAIL ones_i8b3: got %0d ones expected 30", ones_b);
    end

    phase = 2;
    for (int i = 0; i < 100; i++) drive(1'b0);

    phase = 3;
    for (int i = 0; i < 7; i++) drive(1'b1);
    drive(1'b0);
    for (int i = 0; i < 40; i++) drive(1'b1);

    phase = 4;
    drive(1'b0);
    for (int i = 0; i < 6; i++) drive(1'b1);
    drive(1'b0);
    for (int i = 0; i < 20; i++) drive(1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
